key_event: RTL and testbench

- Consumes the active-low, already-debounced key signal from the input-conditioning filter and turns it into discrete, one-cycle key events:
  - press
  - release
  - long-press
  - auto-repeat
- Sits between the debounce stage and UI/control logic.
- A free-running event counter lets software poll for activity.

---
 rtl/key_event_pkg.sv | 15 +
 rtl/key_event_counter.sv | 23 ++
 rtl/key_event.sv | 120 ++++++++++++
 tb/tb_key_event.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/key_event_pkg.sv
// Shared definitions for the key event decoder: state encoding and default timing.
package key_event_pkg;

  typedef enum logic [1:0] {
    KEY_ST_IDLE    = 2'd0,
    KEY_ST_PRESSED = 2'd1,
    KEY_ST_REPEAT  = 2'd2
  } key_state_t;

  localparam int DEFAULT_LONG_PRESS_CYCLES    = 8;
  localparam int DEFAULT_REPEAT_PERIOD_CYCLES = 4;
  localparam int DEFAULT_COUNT_BIT_WIDTH      = 4;
  localparam int DEFAULT_EVENT_COUNT_WIDTH    = 8;

endpackage

// File: rtl/key_event_counter.sv
// Wrapping event counter with synchronous clear and increment enable.
module key_event_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/key_event.sv
// Turns a debounced active-low key into registered press/release/long/repeat pulses
// and keeps a wrapping count of press plus repeat events.
module key_event
  import key_event_pkg::*;
#(
  parameter int LONG_PRESS_CYCLES    = DEFAULT_LONG_PRESS_CYCLES,
  parameter int REPEAT_PERIOD_CYCLES = DEFAULT_REPEAT_PERIOD_CYCLES,
  parameter int COUNT_BIT_WIDTH      = DEFAULT_COUNT_BIT_WIDTH,
  parameter int EVENT_COUNT_WIDTH    = DEFAULT_EVENT_COUNT_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tick,
  input  logic                         signal_debounced_n,
  output logic                         key_press,
  output logic                         key_release,
  output logic                         key_long,
  output logic                         key_repeat,
  output logic                         key_held,
  output logic [EVENT_COUNT_WIDTH-1:0] event_count
);

  if (LONG_PRESS_CYCLES < 1 || LONG_PRESS_CYCLES > (1 << COUNT_BIT_WIDTH)) begin : g_bad_long
    $error("key_event: LONG_PRESS_CYCLES out of range");
  end
  if (REPEAT_PERIOD_CYCLES < 1 || REPEAT_PERIOD_CYCLES > (1 << COUNT_BIT_WIDTH)) begin : g_bad_repeat
    $error("key_event: REPEAT_PERIOD_CYCLES out of range");
  end

  localparam logic [COUNT_BIT_WIDTH-1:0] LONG_LAST   = COUNT_BIT_WIDTH'(LONG_PRESS_CYCLES - 1);
  localparam logic [COUNT_BIT_WIDTH-1:0] REPEAT_LAST = COUNT_BIT_WIDTH'(REPEAT_PERIOD_CYCLES - 1);

  key_state_t                 r_state;
  key_state_t                 w_next_state;
  logic [COUNT_BIT_WIDTH-1:0] r_count;
  logic [COUNT_BIT_WIDTH-1:0] w_next_count;
  logic                       w_press;
  logic                       w_release;
  logic                       w_long;
  logic                       w_repeat;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= KEY_ST_IDLE;
      r_count     <= '0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
      key_repeat  <= 1'b0;
      key_held    <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_count     <= w_next_count;
      key_press   <= w_press;
      key_release <= w_release;
      key_long    <= w_long;
      key_repeat  <= w_repeat;
      key_held    <= (w_next_state != KEY_ST_IDLE);
    end
  end

  // Release is tested before tick so a release never coincides with long/repeat.
  always_comb begin
    w_next_state = r_state;
    w_next_count = r_count;
    w_press      = 1'b0;
    w_release    = 1'b0;
    w_long       = 1'b0;
    w_repeat     = 1'b0;
    case (r_state)
      KEY_ST_IDLE: begin
        if (!signal_debounced_n) begin
          w_next_state = KEY_ST_PRESSED;
          w_press      = 1'b1;
          w_next_count = '0;
        end
      end
      KEY_ST_PRESSED: begin
        if (signal_debounced_n) begin
          w_next_state = KEY_ST_IDLE;
          w_release    = 1'b1;
          w_next_count = '0;
        end else if (tick && r_count == LONG_LAST) begin
          w_next_state = KEY_ST_REPEAT;
          w_long       = 1'b1;
          w_next_count = '0;
        end else if (tick) begin
          w_next_count = r_count + 1'b1;
        end
      end
      KEY_ST_REPEAT: begin
        if (signal_debounced_n) begin
          w_next_state = KEY_ST_IDLE;
          w_release    = 1'b1;
          w_next_count = '0;
        end else if (tick && r_count == REPEAT_LAST) begin
          w_repeat     = 1'b1;
          w_next_count = '0;
        end else if (tick) begin
          w_next_count = r_count + 1'b1;
        end
      end
      default: begin
        w_next_state = KEY_ST_IDLE;
        w_next_count = '0;
      end
    endcase
  end

  // Counting the same pulses that are being registered keeps event_count aligned with them.
  key_event_counter #(
    .WIDTH(EVENT_COUNT_WIDTH)
  ) u_counter (
    .clk    (clk),
    .i_clear(reset),
    .i_inc  (w_press | w_repeat),
    .o_count(event_count)
  );

endmodule

// File: tb/tb_key_event.sv
// Self-checking bench for key_event: a tick-counting model checks two instances
// (default parameters and a narrow, fast-repeat variant) every cycle.
module tb_key_event;

  localparam int LONG0 = 8;
  localparam int REP0  = 4;
  localparam int ECW0  = 8;
  localparam int LONG1 = 8;
  localparam int REP1  = 1;
  localparam int ECW1  = 2;

  logic clk;
  logic reset;
  logic tick;
  logic sigN;

  logic       pressA, releaseA, longA, repeatA, heldA;
  logic [7:0] countA;
  logic       pressB, releaseB, longB, repeatB, heldB;
  logic [1:0] countB;

  int vectors;
  int miscompares;

  int mTicks[2];
  bit mHeld[2];
  int mEvents[2];
  bit ePress[2];
  bit eRelease[2];
  bit eLong[2];
  bit eRepeat[2];

  key_event #(
    .LONG_PRESS_CYCLES(LONG0), .REPEAT_PERIOD_CYCLES(REP0),
    .COUNT_BIT_WIDTH(4), .EVENT_COUNT_WIDTH(ECW0)
  ) dutA (
    .clk(clk), .reset(reset), .tick(tick), .signal_debounced_n(sigN),
    .key_press(pressA), .key_release(releaseA), .key_long(longA),
    .key_repeat(repeatA), .key_held(heldA), .event_count(countA)
  );

  key_event #(
    .LONG_PRESS_CYCLES(LONG1), .REPEAT_PERIOD_CYCLES(REP1),
    .COUNT_BIT_WIDTH(4), .EVENT_COUNT_WIDTH(ECW1)
  ) dutB (
    .clk(clk), .reset(reset), .tick(tick), .signal_debounced_n(sigN),
    .key_press(pressB), .key_release(releaseB), .key_long(longB),
    .key_repeat(repeatB), .key_held(heldB), .event_count(countB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: counts ticks held since the press; long at tick LONG, repeat every REP ticks after.
  task automatic modelStep(input int idx, input int longC, input int repC, input int evMod);
    ePress[idx]   = 1'b0;
    eRelease[idx] = 1'b0;
    eLong[idx]    = 1'b0;
    eRepeat[idx]  = 1'b0;
    if (reset) begin
      mHeld[idx]   = 1'b0;
      mTicks[idx]  = 0;
      mEvents[idx] = 0;
    end else if (!mHeld[idx]) begin
      if (!sigN) begin
        mHeld[idx]   = 1'b1;
        mTicks[idx]  = 0;
        ePress[idx]  = 1'b1;
        mEvents[idx] = (mEvents[idx] + 1) % evMod;
      end
    end else if (sigN) begin
      mHeld[idx]    = 1'b0;
      eRelease[idx] = 1'b1;
    end else if (tick) begin
      mTicks[idx]++;
      if (mTicks[idx] == longC) begin
        eLong[idx] = 1'b1;
      end else if (mTicks[idx] > longC && ((mTicks[idx] - longC) % repC) == 0) begin
        eRepeat[idx] = 1'b1;
        mEvents[idx] = (mEvents[idx] + 1) % evMod;
      end
    end
  endtask

  always @(posedge clk) begin
    modelStep(0, LONG0, REP0, 1 << ECW0);
    modelStep(1, LONG1, REP1, 1 << ECW1);
    #1;
    checkOutput("A.key_press",   pressA,   ePress[0]);
    checkOutput("A.key_release", releaseA, eRelease[0]);
    checkOutput("A.key_long",    longA,    eLong[0]);
    checkOutput("A.key_repeat",  repeatA,  eRepeat[0]);
    checkOutput("A.key_held",    heldA,    mHeld[0]);
    checkOutput("A.event_count", countA,   mEvents[0]);
    checkOutput("B.key_press",   pressB,   ePress[1]);
    checkOutput("B.key_release", releaseB, eRelease[1]);
    checkOutput("B.key_long",    longB,    eLong[1]);
    checkOutput("B.key_repeat",  repeatB,  eRepeat[1]);
    checkOutput("B.key_held",    heldB,    mHeld[1]);
    checkOutput("B.event_count", countB,   mEvents[1]);
  end

  task automatic applyStimulus(input logic rst, input logic keyN, input logic tk);
    @(negedge clk);
    reset = rst;
    sigN  = keyN;
    tick  = tk;
    @(posedge clk);
    #2;
  endtask

  initial begin
    int longPulses;
    int seq[4];
    vectors     = 0;
    miscompares = 0;
    reset = 1'b1;
    sigN  = 1'b1;
    tick  = 1'b0;

    // Reset, then idle with ticks running
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("reset.key_held", heldA, 0);
    checkOutput("reset.event_count", countA, 0);
    for (int k = 0; k < 20; k++) applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("idle.event_count", countA, 0);
    checkOutput("idle.key_held", heldA, 0);

    // Long hold with default timing, release at E22
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("hold.press_E0", pressA, 1);
    for (int k = 1; k <= 22; k++) begin
      applyStimulus(1'b0, (k == 22) ? 1'b1 : 1'b0, 1'b1);
      if (k == 7)  checkOutput("hold.no_long_E7", longA, 0);
      if (k == 8)  checkOutput("hold.long_E8", longA, 1);
      if (k == 12) checkOutput("hold.repeat_E12", repeatA, 1);
      if (k == 16) checkOutput("hold.repeat_E16", repeatA, 1);
      if (k == 20) checkOutput("hold.count_E20", countA, 4);
      if (k == 22) checkOutput("hold.release_E22", releaseA, 1);
    end
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("hold.held_after", heldA, 0);

    // Single-cycle press
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("short.press", pressA, 1);
    checkOutput("short.held", heldA, 1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("short.release", releaseA, 1);
    checkOutput("short.held_off", heldA, 0);
    checkOutput("short.event_count", countA, 1);
    for (int k = 0; k < 10; k++) applyStimulus(1'b0, 1'b1, 1'b1);

    // Sparse ticks: long after exactly 8 ticks (every 3rd cycle)
    applyStimulus(1'b0, 1'b0, 1'b1);
    longPulses = 0;
    for (int k = 1; k <= 24; k++) begin
      applyStimulus(1'b0, 1'b0, (k % 3) == 0);
      if (longA) longPulses++;
    end
    checkOutput("sparse.long_at_tick8", longA, 1);
    checkOutput("sparse.long_pulses", longPulses, 1);
    applyStimulus(1'b0, 1'b1, 1'b0);

    // Release coincident with the 8th tick
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 24; k++) applyStimulus(1'b0, (k == 24) ? 1'b1 : 1'b0, (k % 3) == 0);
    checkOutput("race.release", releaseA, 1);
    checkOutput("race.no_long", longA, 0);

    // Reset while in REPEAT with key still down
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 10; k++) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("midreset.in_repeat_held", heldA, 1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("midreset.held", heldA, 0);
    checkOutput("midreset.count", countA, 0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("midreset.fresh_press", pressA, 1);
    checkOutput("midreset.count_after", countA, 1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("midreset.no_release", releaseA, 0);

    // Narrow counter wrap on instance B (repeat every tick)
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("wrap.count_press", countB, 1);
    for (int k = 1; k <= 8; k++) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("wrap.long", longB, 1);
    seq = '{2, 3, 0, 1};
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("wrap.count_seq", countB, seq[k]);
    end
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
